// File: rtl/kmac_pkg.sv
// Shared KMAC definitions: loader FSM states and default block/key geometry.
// Used by the message loader and the KMAC core.
package kmac_pkg;

  localparam int unsigned RATE_BITS_DEFAULT = 1088;
  localparam int unsigned KEY_BITS_DEFAULT  = 128;
  localparam int unsigned MAC_BITS          = 256;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LAUNCH,
    WAIT_MAC,
    HOLD
  } kmac_state_e;

endpackage

// File: rtl/kmac_msg_loader.sv
// Packs a byte stream into one rate-sized block, launches the KMAC core and
// holds the resulting MAC until the consumer takes it.
module kmac_msg_loader
  import kmac_pkg::*;
#(
  parameter int unsigned RATE_BITS = RATE_BITS_DEFAULT,
  parameter int unsigned KEY_BITS  = KEY_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  input  logic [KEY_BITS-1:0]  key_in,
  output logic [RATE_BITS-1:0] msg_block,
  output logic [15:0]          msg_bit_len,
  output logic [KEY_BITS-1:0]  key,
  output logic                 start,
  input  logic                 mac_done,
  input  logic [MAC_BITS-1:0]  mac_in,
  output logic [MAC_BITS-1:0]  mac_result,
  output logic                 mac_valid,
  input  logic                 mac_ready,
  output logic                 len_overflow
);

  localparam int unsigned RATE_BYTES = RATE_BITS / 8;
  localparam int unsigned CNT_W      = $clog2(RATE_BYTES + 1);

  kmac_state_e          state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [RATE_BITS-1:0] msg_block_q, msg_block_d;
  logic [15:0]          msg_bit_len_q, msg_bit_len_d;
  logic [KEY_BITS-1:0]  key_q, key_d;
  logic [MAC_BITS-1:0]  mac_result_q, mac_result_d;
  logic                 len_overflow_q, len_overflow_d;

  logic             transfer;
  logic [CNT_W-1:0] count_inc;
  logic             block_full;

  assign s_ready    = (state_q == IDLE) || (state_q == FILL);
  assign transfer   = s_valid && s_ready;
  assign count_inc  = count_q + CNT_W'(1);
  assign block_full = (count_inc == CNT_W'(RATE_BYTES));

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    msg_block_d    = msg_block_q;
    msg_bit_len_d  = msg_bit_len_q;
    key_d          = key_q;
    mac_result_d   = mac_result_q;
    len_overflow_d = len_overflow_q;

    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          key_d          = key_in;
          len_overflow_d = block_full && !s_last;
          msg_block_d    = '0;
          msg_block_d[7:0] = s_data;
          count_d        = CNT_W'(1);
          msg_bit_len_d  = 16'({count_inc, 3'b000});
          state_d        = (s_last || block_full) ? LAUNCH : FILL;
        end
      end
      FILL: begin
        if (transfer) begin
          msg_block_d[{count_q, 3'b000} +: 8] = s_data;
          count_d        = count_inc;
          msg_bit_len_d  = 16'({count_inc, 3'b000});
          // A full block without s_last truncates the message; flag it.
          len_overflow_d = block_full && !s_last;
          if (s_last || block_full) begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT_MAC;
      end
      WAIT_MAC: begin
        if (mac_done) begin
          mac_result_d = mac_in;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (mac_ready) begin
          msg_block_d = '0;
          count_d     = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      count_q        <= '0;
      msg_block_q    <= '0;
      msg_bit_len_q  <= '0;
      key_q          <= '0;
      mac_result_q   <= '0;
      len_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      msg_block_q    <= msg_block_d;
      msg_bit_len_q  <= msg_bit_len_d;
      key_q          <= key_d;
      mac_result_q   <= mac_result_d;
      len_overflow_q <= len_overflow_d;
    end
  end

  assign msg_block    = msg_block_q;
  assign msg_bit_len  = msg_bit_len_q;
  assign key          = key_q;
  assign mac_result   = mac_result_q;
  assign len_overflow = len_overflow_q;
  assign start        = (state_q == LAUNCH);
  assign mac_valid    = (state_q == HOLD);

endmodule

// File: tb/tb_kmac_msg_loader.sv
// Directed bench for kmac_msg_loader: a message-level model (byte queue plus
// protocol phase) is compared against the DUT every cycle, with literal spot checks.
module tb_kmac_msg_loader;

  localparam int RB = 1088;
  localparam int KB = 128;
  localparam int RBYTES = RB / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [KB-1:0] key_in;
  logic [RB-1:0] msg_block;
  logic [15:0]   msg_bit_len;
  logic [KB-1:0] key;
  logic          start;
  logic          mac_done;
  logic [255:0]  mac_in;
  logic [255:0]  mac_result;
  logic          mac_valid;
  logic          mac_ready;
  logic          len_overflow;

  kmac_msg_loader dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .key_in(key_in), .msg_block(msg_block), .msg_bit_len(msg_bit_len), .key(key),
    .start(start), .mac_done(mac_done), .mac_in(mac_in),
    .mac_result(mac_result), .mac_valid(mac_valid), .mac_ready(mac_ready),
    .len_overflow(len_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Message-level model
  logic [7:0]    exp_q[$];
  logic [KB-1:0] exp_key;
  logic [15:0]   exp_len;
  logic [255:0]  exp_mac;
  bit            exp_ovf;
  bit            accepting, launched, waiting, holding, fresh;

  function automatic logic [RB-1:0] model_block();
    logic [RB-1:0] r = '0;
    for (int i = 0; i < exp_q.size(); i++) r[8*i +: 8] = exp_q[i];
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_key = '0; exp_len = '0; exp_mac = '0; exp_ovf = 0;
    accepting = 1; launched = 0; waiting = 0; holding = 0; fresh = 1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic chk_blk(input string name, input logic [RB-1:0] act, input logic [RB-1:0] want);
    int first;
    total++;
    if (act !== want) begin
      bad++;
      first = -1;
      for (int i = RBYTES - 1; i >= 0; i--) if (act[8*i +: 8] !== want[8*i +: 8]) first = i;
      $display("FAIL %s: byte %0d got %0h expected %0h, low64 got %0h expected %0h (t=%0t)",
               name, first, act[8*first +: 8], want[8*first +: 8], act[63:0], want[63:0], $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk_blk("msg_block", msg_block, model_block());
      if (!(accepting && !fresh)) chk("msg_bit_len", 256'(msg_bit_len), 256'(exp_len));
      chk("key", 256'(key), 256'(exp_key));
      chk("len_overflow", 256'(len_overflow), 256'(exp_ovf));
      chk("s_ready", 256'(s_ready), 256'(accepting));
      chk("start", 256'(start), 256'(launched));
      chk("mac_valid", 256'(mac_valid), 256'(holding));
      chk("mac_result", mac_result, exp_mac);
    end
  end

  // Advance one clock and apply the protocol effect of the inputs seen at that edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_n) return;
    if (accepting && s_valid) begin
      if (fresh) begin
        exp_key = key_in;
        exp_ovf = 0;
        fresh   = 0;
      end
      exp_q.push_back(s_data);
      if (s_last || exp_q.size() == RBYTES) begin
        accepting = 0;
        launched  = 1;
        exp_len   = 16'(8 * exp_q.size());
        exp_ovf   = !s_last;
      end
    end else if (launched) begin
      launched = 0;
      waiting  = 1;
    end else if (waiting && mac_done) begin
      exp_mac = mac_in;
      waiting = 0;
      holding = 1;
    end else if (holding && mac_ready) begin
      holding   = 0;
      accepting = 1;
      fresh     = 1;
      exp_q.delete();
    end
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    s_valid = 1; s_data = d; s_last = last;
    step();
    s_valid = 0; s_last = 0;
  endtask

  // Launch -> wait -> capture -> hold for hold_cycles -> handshake.
  task automatic finish_mac(input logic [255:0] val, input int hold_cycles);
    s_valid = 1; s_data = 8'hEE; s_last = 0;
    step();
    step();
    s_valid = 0;
    mac_done = 1; mac_in = val;
    step();
    mac_done = 0; mac_in = ~val;
    chk("mac_result_literal", mac_result, val);
    for (int i = 0; i < hold_cycles; i++) begin
      mac_done = (i == 1);
      step();
      chk("mac_held", mac_result, val);
      chk("mac_valid_held", 256'(mac_valid), 256'(1));
    end
    mac_done = 0;
    mac_ready = 1;
    step();
    mac_ready = 0;
    chk("block_cleared", 256'(msg_block == '0), 256'(1));
    chk("ready_after_hold", 256'(s_ready), 256'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; s_data = 0; s_valid = 0; s_last = 0; key_in = '0;
    mac_done = 0; mac_in = '0; mac_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    chk("reset_bit_len", 256'(msg_bit_len), 256'(0));
    chk("reset_key", 256'(key), 256'(0));
    chk("reset_start", 256'(start), 256'(0));
    step();
    rst_n = 1;
    step();
    chk("ready_after_release", 256'(s_ready), 256'(1));

    // "abc", key change after first byte, stray mac_done while filling
    key_in = 128'h000102030405060708090a0b0c0d0e0f;
    send(8'h61, 0);
    key_in = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    mac_done = 1; mac_in = {8{32'h12345678}};
    step();
    mac_done = 0;
    send(8'h62, 0);
    send(8'h63, 1);
    chk("abc_start", 256'(start), 256'(1));
    chk("abc_low", 256'(msg_block[23:0]), 256'(24'h636261));
    chk("abc_upper_zero", 256'(msg_block[RB-1:24] == '0), 256'(1));
    chk("abc_bit_len", 256'(msg_bit_len), 256'(24));
    chk("abc_key", 256'(key), 256'(128'h000102030405060708090a0b0c0d0e0f));
    finish_mac({8{32'hCAFEF00D}}, 1);

    // Full block terminated by s_last
    key_in = 128'h11112222333344445555666677778888;
    for (int i = 0; i < RBYTES; i++) send(8'(i + 1), i == RBYTES - 1);
    chk("full_bit_len", 256'(msg_bit_len), 256'(1088));
    chk("full_ovf", 256'(len_overflow), 256'(0));
    chk("full_ready", 256'(s_ready), 256'(0));
    finish_mac({16{16'h3C5A}}, 2);

    // Full block without s_last: overflow
    for (int i = 0; i < RBYTES; i++) send(8'(255 - i), 0);
    chk("ovf_flag", 256'(len_overflow), 256'(1));
    chk("ovf_bit_len", 256'(msg_bit_len), 256'(1088));
    finish_mac({32{8'hA5}}, 5);
    chk("ovf_sticky", 256'(len_overflow), 256'(1));
    send(8'h11, 1);
    chk("ovf_cleared", 256'(len_overflow), 256'(0));
    chk("one_byte_len", 256'(msg_bit_len), 256'(8));
    finish_mac({4{64'h0123456789abcdef}}, 0);

    // Reset mid-message
    for (int i = 0; i < 10; i++) send(8'(8'h30 + i), 0);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_block", 256'(msg_block == '0), 256'(1));
    chk("rst_key", 256'(key), 256'(0));
    chk("rst_len", 256'(msg_bit_len), 256'(0));
    chk("rst_mac", mac_result, 256'(0));
    step();
    rst_n = 1;
    mac_done = 1; mac_in = {8{32'hFFFF0000}};
    step();
    mac_done = 0;
    chk("stray_mac_valid", 256'(mac_valid), 256'(0));
    send(8'h5A, 1);
    chk("post_rst_len", 256'(msg_bit_len), 256'(8));
    chk("post_rst_byte", 256'(msg_block[7:0]), 256'(8'h5A));
    finish_mac({8{32'h0F0F1E1E}}, 1);

    step();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kmac_msg_loader.md
KMAC_MSG_LOADER -- requirements
Module: kmac_msg_loader

Interface
REQ-001 SHALL have parameter RATE_BITS, default 1088, block width in bits; RATE_BYTES = RATE_BITS/8 (136).
REQ-002 SHALL have parameter KEY_BITS, default 128, key width.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_data  input  8  message byte.
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_last  input  1  final byte of message, qualified by s_valid.
REQ-008 s_ready  output  1  loader accepts byte; transfer = s_valid & s_ready.
REQ-009 key_in  input  KEY_BITS  KMAC key for current message.
REQ-010 msg_block  output  RATE_BITS  packed message to KMAC core.
REQ-011 msg_bit_len  output  16  message length in bits.
REQ-012 key  output  KEY_BITS  registered key to KMAC core.
REQ-013 start  output  1  single-cycle launch pulse to KMAC core.
REQ-014 mac_done  input  1  KMAC core completion pulse.
REQ-015 mac_in  input  256  KMAC core result, valid while mac_done=1.
REQ-016 mac_result  output  256  captured MAC.
REQ-017 mac_valid  output  1  mac_result valid.
REQ-018 mac_ready  input  1  consumer accepts mac_result.
REQ-019 len_overflow  output  1  message hit RATE_BYTES without s_last.

Function
REQ-020 FSM states SHALL be IDLE, FILL, LAUNCH, WAIT_MAC, HOLD.
REQ-021 s_ready SHALL be 1 only in IDLE and FILL.
REQ-022 Accepted byte number n (0-based) SHALL be written to msg_block[8n+7:8n]; unwritten bytes SHALL read zero.
REQ-023 IDLE, transfer: capture key_in into key, clear len_overflow, write byte 0, count=1; go FILL, or LAUNCH if s_last.
REQ-024 FILL, transfer: write byte, count+1; go LAUNCH if s_last or count reaches RATE_BYTES.
REQ-025 Reaching RATE_BYTES with s_last=0 SHALL set len_overflow (sticky until next message's first byte); excess bytes are not accepted for this message.
REQ-026 msg_bit_len SHALL equal 8*count, registered, valid from LAUNCH until next message's first byte.
REQ-027 LAUNCH SHALL assert start for exactly one cycle, then go WAIT_MAC; msg_block, msg_bit_len, key SHALL stay stable from LAUNCH through WAIT_MAC.
REQ-028 WAIT_MAC, mac_done=1: capture mac_in into mac_result, go HOLD.
REQ-029 mac_done outside WAIT_MAC SHALL be ignored.
REQ-030 HOLD: mac_valid=1; mac_valid & mac_ready -> IDLE, clear msg_block to zero, count=0.
REQ-031 mac_result SHALL remain stable while mac_valid=1 and until next capture.
REQ-032 Zero-length messages are not supported; s_last always accompanies a data byte.
REQ-033 s_valid without s_ready SHALL not alter state; data is not consumed.

Reset
REQ-034 rst_n low SHALL force IDLE; msg_block, msg_bit_len, key, mac_result, count zero; start, mac_valid, len_overflow 0; s_ready 1 after release.
REQ-035 Reset mid-message or in WAIT_MAC SHALL discard partial block; no start emitted; late mac_done ignored.

Structure
REQ-036 State enum and RATE_BITS/KEY_BITS defaults SHALL live in shared package kmac_pkg, also used by the KMAC core.
REQ-037 No sub-module; single FSM plus byte counter and block register.

Verification
REQ-038 Bytes "abc" (0x61,0x62,0x63, last on 3rd) -> one start pulse, msg_block[23:0]=0x636261, rest zero, msg_bit_len=24.
REQ-039 136 bytes, s_last on 136th -> start after byte 136, msg_bit_len=1088, len_overflow=0, s_ready=0 until HOLD handshake.
REQ-040 136 bytes, no s_last -> LAUNCH, len_overflow=1, msg_bit_len=1088; next message first byte clears it.
REQ-041 mac_done with mac_in=0xA5..A5 while mac_ready=0 for 5 cycles -> mac_valid held, mac_result stable, IDLE one cycle after mac_ready=1, msg_block zero.
REQ-042 rst_n pulse after 10 bytes -> all outputs zero, stray mac_done ignored, new 1-byte message launches with msg_bit_len=8.
REQ-043 key_in changed after first byte -> key output retains value sampled at first byte.
